pebbles_stream_arbiter: RTL and testbench

//   Round-robin arbiter merging NUM_IN 8-bit byte streams (one per pebbles_core

---
 rtl/pebbles_stream_arbiter.sv | 149 ++++++++++++++
 tb/tb_pebbles_stream_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pebbles_stream_arbiter.sv
// pebbles_stream_arbiter: round-robin merge of NUM_IN byte streams onto one
// console stream. A grant lasts for a whole message: it ends on EOL_BYTE,
// after MAX_BURST payload bytes, or after IDLE_TIMEOUT idle cycles. When
// TAG_EN is set, each grant starts with a tag byte 8'h80|index. The output
// is a single register slot, so a new byte can load while the sink takes the
// old one.
module pebbles_stream_arbiter #(
   parameter int         NUM_IN       = 4,
   parameter int         MAX_BURST    = 64,
   parameter int         IDLE_TIMEOUT = 255,
   parameter bit         TAG_EN       = 1'b1,
   parameter logic [7:0] EOL_BYTE     = 8'h0A
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_IN-1:0]   in_canPeek,
   input  logic [8*NUM_IN-1:0] in_peek,
   output logic [NUM_IN-1:0]   in_consume_en,
   input  logic                out_consume_en,
   output logic                out_canPeek,
   output logic [7:0]          out_peek
);

   localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_TAG,
      S_STREAM
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [7:0]       burst_cnt_q, burst_cnt_d;
   logic [7:0]       idle_cnt_q, idle_cnt_d;
   logic             ovalid_q, ovalid_d;
   logic [7:0]       odata_q, odata_d;

   logic             load_ok;
   logic [7:0]       grant_byte;
   logic [8:0]       burst_inc;
   logic [8:0]       idle_inc;
   logic [IDX_W-1:0] rr_pick;
   logic [IDX_W-1:0] rr_cand;
   logic             rr_found;

   assign load_ok     = ~ovalid_q | out_consume_en;
   assign grant_byte  = in_peek[{grant_q, 3'b000} +: 8];
   assign burst_inc   = {1'b0, burst_cnt_q} + 9'd1;
   assign idle_inc    = {1'b0, idle_cnt_q} + 9'd1;
   assign out_canPeek = ovalid_q;
   assign out_peek    = odata_q;

   // Round-robin pick: first requester scanning last+1, last+2, ... (wrapping),
   // so the most recently released source has the lowest priority.
   always_comb begin
      rr_pick  = last_q;
      rr_cand  = last_q;
      rr_found = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         rr_cand = (rr_cand == IDX_W'(NUM_IN - 1)) ? '0 : rr_cand + IDX_W'(1);
         if (!rr_found && in_canPeek[rr_cand]) begin
            rr_found = 1'b1;
            rr_pick  = rr_cand;
         end
      end
   end

   // Next-state, output-register and consume logic for the grant FSM.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      burst_cnt_d   = burst_cnt_q;
      idle_cnt_d    = idle_cnt_q;
      ovalid_d      = ovalid_q & ~out_consume_en;
      odata_d       = odata_q;
      in_consume_en = '0;

      unique case (state_q)
         S_IDLE: begin
            // One-cycle arbitration bubble: nothing moves from the inputs here.
            if (|in_canPeek) begin
               grant_d     = rr_pick;
               state_d     = TAG_EN ? S_TAG : S_STREAM;
               burst_cnt_d = '0;
               idle_cnt_d  = '0;
            end
         end
         S_TAG: begin
            if (load_ok) begin
               odata_d  = 8'h80 | 8'(grant_q);
               ovalid_d = 1'b1;
               state_d  = S_STREAM;
            end
         end
         S_STREAM: begin
            if (load_ok && in_canPeek[grant_q]) begin
               // The consume pulse is suppressed during reset: the transfer
               // would be discarded by the reset, so the byte must stay put.
               in_consume_en[grant_q] = ~reset;
               odata_d     = grant_byte;
               ovalid_d    = 1'b1;
               burst_cnt_d = burst_inc[7:0];
               idle_cnt_d  = '0;
               if (grant_byte == EOL_BYTE || burst_inc == 9'(MAX_BURST)) begin
                  last_d  = grant_q;
                  state_d = S_IDLE;
               end
            end else if (!in_canPeek[grant_q]) begin
               // Only a silent source counts as idle; sink backpressure does not.
               idle_cnt_d = idle_inc[7:0];
               if (idle_inc == 9'(IDLE_TIMEOUT)) begin
                  last_d  = grant_q;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge.
      if (reset) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         last_q      <= IDX_W'(NUM_IN - 1);
         burst_cnt_q <= '0;
         idle_cnt_q  <= '0;
         ovalid_q    <= 1'b0;
         odata_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         burst_cnt_q <= burst_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         ovalid_q    <= ovalid_d;
         odata_q     <= odata_d;
      end
   end

endmodule

// File: tb/tb_pebbles_stream_arbiter.sv
// Testbench for pebbles_stream_arbiter. Each source is a byte queue that
// is popped when the DUT consumes from it. Directed stimulus pushes source
// bytes and the hand-computed output bytes into a scoreboard queue. A
// separate monitor compares every byte the sink accepts.
module tb_pebbles_stream_arbiter;

   localparam int NUM_IN       = 4;
   localparam int MAX_BURST    = 64;
   localparam int IDLE_TIMEOUT = 255;

   logic                clock;
   logic                reset;
   logic [NUM_IN-1:0]   in_canPeek;
   logic [8*NUM_IN-1:0] in_peek;
   logic [NUM_IN-1:0]   in_consume_en;
   logic                out_consume_en;
   logic                out_canPeek;
   logic [7:0]          out_peek;

   logic [7:0] src_q [NUM_IN][$];
   logic [7:0] exp_q [$];

   int n_tests = 0;
   int n_fail  = 0;
   int viol    = 0;
   int cyc     = 0;
   int pop_cnt      [NUM_IN] = '{default: 0};
   int last_pop_cyc [NUM_IN] = '{default: 0};

   pebbles_stream_arbiter #(
      .NUM_IN      (NUM_IN),
      .MAX_BURST   (MAX_BURST),
      .IDLE_TIMEOUT(IDLE_TIMEOUT),
      .TAG_EN      (1'b1),
      .EOL_BYTE    (8'h0A)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .in_canPeek    (in_canPeek),
      .in_peek       (in_peek),
      .in_consume_en (in_consume_en),
      .out_consume_en(out_consume_en),
      .out_canPeek   (out_canPeek),
      .out_peek      (out_peek)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion, required completion within 40000 cycles");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_src(input int src, input string s);
      for (int k = 0; k < s.len(); k++) src_q[src].push_back(s[k]);
   endtask

   task automatic push_exp(input string s);
      for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
   endtask

   task automatic push_tag(input int src);
      exp_q.push_back(8'h80 | 8'(src));
   endtask

   function automatic bit src_empty();
      for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Wait until all expected bytes are seen, then let the grant time out.
   task automatic drain(input string name);
      bit done = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(posedge clock); #2;
         if (exp_q.size() == 0 && src_empty()) begin
            done = 1'b1;
            break;
         end
      end
      check({name, "_drain"}, 32'(done), 32'd1);
      repeat (IDLE_TIMEOUT + 10) @(posedge clock);
      #2;
   endtask

   task automatic wait_pops(input int src, input int target, input string name);
      bit ok = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (pop_cnt[src] >= target) begin
            ok = 1'b1;
            break;
         end
         @(posedge clock); #2;
      end
      check({name, "_pop_wait"}, 32'(ok), 32'd1);
   endtask

   // Source driver: consumes are sampled mid-cycle, applied just after the edge.
   logic [NUM_IN-1:0] drv_cons;
   logic [NUM_IN-1:0] drv_canp;
   initial begin
      in_canPeek = '0;
      in_peek    = '0;
      forever begin
         @(negedge clock);
         drv_cons = in_consume_en;
         drv_canp = in_canPeek;
         @(posedge clock); #1;
         cyc++;
         if ($countones(drv_cons) > 1) viol++;
         for (int i = 0; i < NUM_IN; i++) begin
            if (drv_cons[i]) begin
               if (!drv_canp[i] || src_q[i].size() == 0) viol++;
               else void'(src_q[i].pop_front());
               pop_cnt[i]++;
               last_pop_cyc[i] = cyc;
            end
         end
         for (int i = 0; i < NUM_IN; i++) begin
            in_canPeek[i]      = (src_q[i].size() != 0);
            in_peek[8*i +: 8]  = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
         end
      end
   end

   // Monitor: compare each byte the sink accepts against the scoreboard.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clock);
         if (!reset && out_canPeek && out_consume_en) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL out_unexpected: got %0h, required no byte", out_peek);
            end else begin
               e = exp_q.pop_front();
               check("out_byte", 32'(out_peek), 32'(e));
            end
         end
      end
   end

   initial begin
      int b0, b1, b2, b3;
      logic [7:0] v;
      reset          = 1'b1;
      out_consume_en = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_out_canPeek", 32'(out_canPeek), 32'd0);
      check("rst_out_peek", 32'(out_peek), 32'h00);
      check("rst_in_consume", 32'(in_consume_en), 32'd0);
      @(posedge clock); #2;
      reset = 1'b0;

      // 1: single message from input 2.
      b2 = pop_cnt[2];
      push_src(2, "hi\n");
      push_tag(2); push_exp("hi\n");
      drain("t1");
      check("t1_consumes", 32'(pop_cnt[2] - b2), 32'd3);
      @(negedge clock);
      check("t1_idle_valid", 32'(out_canPeek), 32'd0);
      check("t1_idle_consume", 32'(in_consume_en), 32'd0);
      @(posedge clock); #2;

      // 2: tie between inputs 0 and 1, twice.
      b0 = pop_cnt[0]; b1 = pop_cnt[1];
      for (int r = 0; r < 2; r++) begin
         push_src(0, "a\n"); push_src(1, "a\n");
         push_tag(0); push_exp("a\n");
         push_tag(1); push_exp("a\n");
         drain("t2");
      end
      check("t2_consumes0", 32'(pop_cnt[0] - b0), 32'd4);
      check("t2_consumes1", 32'(pop_cnt[1] - b1), 32'd4);

      // 3: 100 bytes without EOL from input 3, split at MAX_BURST.
      b3 = pop_cnt[3];
      push_tag(3);
      for (int k = 0; k < 100; k++) begin
         v = 8'(8'h30 + (k % 64));
         src_q[3].push_back(v);
         if (k == MAX_BURST) push_tag(3);
         exp_q.push_back(v);
      end
      drain("t3");
      check("t3_consumes", 32'(pop_cnt[3] - b3), 32'd100);

      // 4: input 1 stalls after 'x'; input 0 gets the grant after the timeout.
      b0 = pop_cnt[0]; b1 = pop_cnt[1];
      push_src(1, "x");
      push_tag(1); push_exp("x");
      wait_pops(1, b1 + 1, "t4_x");
      push_src(0, "a\n");
      push_tag(0); push_exp("a\n");
      wait_pops(0, b0 + 1, "t4_a");
      // x at edge t; timeout to IDLE at t+255; grant t+256; tag t+257; 'a' t+258.
      check("t4_timeout_gap", 32'(last_pop_cyc[0] - last_pop_cyc[1]), 32'd258);
      drain("t4");

      // 5: sink backpressure for 10 cycles mid-message.
      b2 = pop_cnt[2];
      push_src(2, "abcdef\n");
      push_tag(2); push_exp("abcdef\n");
      wait_pops(2, b2 + 2, "t5");
      out_consume_en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         check("t5_hold_valid", 32'(out_canPeek), 32'd1);
         check("t5_hold_byte", 32'(out_peek), 32'h62);
         check("t5_no_consume", 32'(in_consume_en), 32'd0);
      end
      @(posedge clock); #2;
      out_consume_en = 1'b1;
      drain("t5");
      check("t5_consumes", 32'(pop_cnt[2] - b2), 32'd7);

      // 6: reset mid-STREAM, then input 0 wins a tie with input 1.
      b1 = pop_cnt[1];
      push_tag(1);
      for (int k = 0; k < 20; k++) begin
         v = 8'(8'h40 + k);
         src_q[1].push_back(v);
         exp_q.push_back(v);
      end
      wait_pops(1, b1 + 5, "t6");
      out_consume_en = 1'b0;
      reset          = 1'b1;
      for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
      exp_q.delete();
      @(negedge clock);
      check("t6_rst_cycle_consume", 32'(in_consume_en), 32'd0);
      @(posedge clock); #2;
      reset = 1'b0;
      @(negedge clock);
      check("t6_post_rst_valid", 32'(out_canPeek), 32'd0);
      check("t6_post_rst_peek", 32'(out_peek), 32'h00);
      check("t6_post_rst_consume", 32'(in_consume_en), 32'd0);
      @(posedge clock); #2;
      out_consume_en = 1'b1;
      push_src(0, "z\n"); push_src(1, "z\n");
      push_tag(0); push_exp("z\n");
      push_tag(1); push_exp("z\n");
      drain("t6");

      check("stream_rule_violations", 32'(viol), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
